// File: rtl/stopwatch_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stopwatch_timer                                                |
// | Purpose  : MM:SS.CC BCD stopwatch (count up) / timer (count down) with    |
// |            preset load, run control, terminal-count done flag, periodic  |
// |            alarm toggle and a lap-capture FIFO.                          |
// | Ports    : clk_100hz, rst (sync, active-high)                             |
// |            start/stop/clear/load/mode/load_time : run control & preset   |
// |            lap/lap_pop                          : lap FIFO push/pop      |
// |            time_bcd/running/done/wrap/alarm     : time and status        |
// |            lap_time/lap_empty/lap_full/lap_ovf  : lap FIFO head & flags  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module stopwatch_timer #(
  parameter int TICK_DIV         = 1,
  parameter int ALARM_PERIOD_SEC = 30,
  parameter int LAP_DEPTH        = 4
) (
  input  logic        clk_100hz,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        mode,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        lap,
  input  logic        lap_pop,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        done,
  output logic        wrap,
  output logic        alarm,
  output logic [23:0] lap_time,
  output logic        lap_empty,
  output logic        lap_full,
  output logic        lap_ovf
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W = $clog2(LAP_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [6:0] ALARM_P = 7'(ALARM_PERIOD_SEC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Upper limit of each digit, nibble 0 = cs_l ... nibble 5 = min_h.
  function automatic logic [3:0] digit_max(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

  // Returns {carry_out, incremented time}; carry_out marks 59:59.99 -> 0.
  function automatic logic [24:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (t[4*i +: 4] == digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = t[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [23:0] r;
    logic        b;
    r = t;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (b) begin
        if (t[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = digit_max(i);
        end else begin
          r[4*i +: 4] = t[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[4*i +: 4] > digit_max(i)) ok = 1'b0;
    end
    return ok;
  endfunction

  state_t             state_q, state_d;
  logic [23:0]        time_q, time_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mode_q, mode_d;
  logic               alarm_q, alarm_d;
  logic               wrap_q, wrap_d;

  logic [23:0]        mem_q [LAP_DEPTH];
  logic [23:0]        mem_d [LAP_DEPTH];
  logic [PTR_W:0]     wr_q, wr_d, rd_q, rd_d;
  logic               ovf_q, ovf_d;

  logic [24:0]        inc_res;
  logic [23:0]        dec_res;
  logic [23:0]        next_t;
  logic [6:0]         secs;
  logic               load_ok;
  logic               fifo_empty, fifo_full, push_req, do_push, do_pop;

  assign inc_res = bcd_inc(time_q);
  assign dec_res = bcd_dec(time_q);
  assign next_t  = mode_q ? dec_res : inc_res[23:0];
  assign secs    = 7'(next_t[15:12]) * 7'd10 + 7'(next_t[11:8]);
  assign load_ok = load && (state_q != S_RUN) && digits_ok(load_time);

  // Control / time path. Priority: clear > load > stop > start; ignored
  // commands fall through so a running counter keeps ticking.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    div_d   = div_q;
    mode_d  = mode_q;
    alarm_d = alarm_q;
    wrap_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      time_d  = 24'h0;
      div_d   = '0;
      alarm_d = 1'b0;
    end else if (load_ok) begin
      time_d = load_time;
      div_d  = '0;
      if (state_q == S_DONE) state_d = S_IDLE;
    end else if (stop && state_q == S_RUN) begin
      state_d = S_PAUSE;
    end else if (start && state_q == S_IDLE && !(mode && time_q == 24'h0)) begin
      state_d = S_RUN;
      mode_d  = mode;
      div_d   = '0;
    end else if (start && state_q == S_PAUSE) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        time_d = next_t;
        wrap_d = !mode_q && inc_res[24];
        if (mode_q && next_t == 24'h0) state_d = S_DONE;
        if (next_t[7:0] == 8'h00 && (secs % ALARM_P) == 7'd0) alarm_d = ~alarm_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Lap FIFO: pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                      (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign push_req   = lap && (state_q == S_RUN || state_q == S_PAUSE);
  assign do_pop     = lap_pop && !fifo_empty;
  // When full, a simultaneous pop frees the head slot that the push reuses.
  assign do_push    = push_req && (!fifo_full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_q[PTR_W-1:0]] = time_q;
        wr_d = wr_q + (PTR_W+1)'(1);
      end
      if (do_pop) rd_d = rd_q + (PTR_W+1)'(1);
      if (push_req && fifo_full && !do_pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100hz) begin
    if (rst) begin
      state_q <= S_IDLE;
      time_q  <= 24'h0;
      div_q   <= '0;
      mode_q  <= 1'b0;
      alarm_q <= 1'b0;
      wrap_q  <= 1'b0;
      mem_q   <= '{default: 24'h0};
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      alarm_q <= alarm_d;
      wrap_q  <= wrap_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign time_bcd  = time_q;
  assign running   = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign wrap      = wrap_q;
  assign alarm     = alarm_q;
  assign lap_time  = mem_q[rd_q[PTR_W-1:0]];
  assign lap_empty = fifo_empty;
  assign lap_full  = fifo_full;
  assign lap_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_stopwatch_timer                                             |
// | Purpose  : Directed self-checking bench for stopwatch_timer; one instance |
// |            with TICK_DIV=1 and one with TICK_DIV=4 share the stimulus.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_stopwatch_timer;

  logic        clk_100hz = 1'b0;
  logic        rst = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0;
  logic        load = 1'b0, lap = 1'b0, lap_pop = 1'b0;
  logic [23:0] load_time = 24'h0;

  logic [23:0] time_bcd, lap_time, t4_time, t4_lap_time;
  logic        running, done, wrap, alarm, lap_empty, lap_full, lap_ovf;
  logic        t4_running, t4_done, t4_wrap, t4_alarm, t4_empty, t4_full, t4_ovf;

  always #5 clk_100hz = ~clk_100hz;

  stopwatch_timer #(.TICK_DIV(1), .ALARM_PERIOD_SEC(30), .LAP_DEPTH(4)) dut (
    .clk_100hz(clk_100hz), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .mode(mode), .load(load), .load_time(load_time), .lap(lap), .lap_pop(lap_pop),
    .time_bcd(time_bcd), .running(running), .done(done), .wrap(wrap), .alarm(alarm),
    .lap_time(lap_time), .lap_empty(lap_empty), .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  stopwatch_timer #(.TICK_DIV(4), .ALARM_PERIOD_SEC(30), .LAP_DEPTH(4)) dut4 (
    .clk_100hz(clk_100hz), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .mode(mode), .load(load), .load_time(load_time), .lap(lap), .lap_pop(lap_pop),
    .time_bcd(t4_time), .running(t4_running), .done(t4_done), .wrap(t4_wrap),
    .alarm(t4_alarm), .lap_time(t4_lap_time), .lap_empty(t4_empty),
    .lap_full(t4_full), .lap_ovf(t4_ovf)
  );

  // Observation selectors
  localparam int O_TIME = 0, O_RUN = 1, O_DONE = 2, O_WRAP = 3, O_ALARM = 4;
  localparam int O_LAPT = 5, O_EMPTY = 6, O_FULL = 7, O_OVF = 8;
  localparam int O4_TIME = 9, O4_RUN = 10;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard of expectations queued with the stimulus, drained after the edge
  string       q_tag [$];
  int          q_sel [$];
  logic [31:0] q_exp [$];

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      O_TIME:  return 32'(time_bcd);
      O_RUN:   return 32'(running);
      O_DONE:  return 32'(done);
      O_WRAP:  return 32'(wrap);
      O_ALARM: return 32'(alarm);
      O_LAPT:  return 32'(lap_time);
      O_EMPTY: return 32'(lap_empty);
      O_FULL:  return 32'(lap_full);
      O_OVF:   return 32'(lap_ovf);
      O4_TIME: return 32'(t4_time);
      O4_RUN:  return 32'(t4_running);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_sel.push_back(sel);
    q_exp.push_back(exp);
  endtask

  task automatic check_now();
    string       tag;
    int          sel;
    logic [31:0] exp, got;
    while (q_sel.size() > 0) begin
      tag = q_tag.pop_front();
      sel = q_sel.pop_front();
      exp = q_exp.pop_front();
      got = obs(sel);
      n_checks++;
      assert (got === exp) begin
        n_pass++;
      end else begin
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
    end
  endtask

  // Advance n clock edges, landing 1 time unit after the last rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100hz);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    cyc(2);
    rst = 1'b0;
    expect_val("rst_time", O_TIME, 32'h0);
    expect_val("rst_running", O_RUN, 32'h0);
    expect_val("rst_done", O_DONE, 32'h0);
    expect_val("rst_wrap", O_WRAP, 32'h0);
    expect_val("rst_alarm", O_ALARM, 32'h0);
    expect_val("rst_empty", O_EMPTY, 32'h1);
    expect_val("rst_full", O_FULL, 32'h0);
    expect_val("rst_ovf", O_OVF, 32'h0);
    check_now();

    // ---------------- up count and alarm ----------------
    mode = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    expect_val("up_start_run", O_RUN, 32'h1);
    expect_val("up_start_time", O_TIME, 32'h0);
    check_now();
    cyc(2999);
    expect_val("up_2999", O_TIME, 32'h002999);
    expect_val("alarm_pre30", O_ALARM, 32'h0);
    check_now();
    cyc(1);
    expect_val("up_3000", O_TIME, 32'h003000);
    expect_val("alarm_at30", O_ALARM, 32'h1);
    check_now();
    cyc(3000);
    expect_val("up_6000", O_TIME, 32'h010000);
    expect_val("alarm_at60", O_ALARM, 32'h0);
    check_now();

    // ---------------- wrap via preset ----------------
    stop = 1'b1; cyc(1); stop = 1'b0;
    expect_val("stop_run", O_RUN, 32'h0);
    expect_val("stop_time", O_TIME, 32'h010000);
    check_now();
    load = 1'b1; load_time = 24'h595990; cyc(1); load = 1'b0;
    expect_val("load_pause", O_TIME, 32'h595990);
    check_now();
    start = 1'b1; cyc(1); start = 1'b0;
    expect_val("resume_run", O_RUN, 32'h1);
    expect_val("resume_time", O_TIME, 32'h595990);
    check_now();
    cyc(9);
    expect_val("pre_wrap", O_TIME, 32'h595999);
    expect_val("pre_wrap_w", O_WRAP, 32'h0);
    check_now();
    cyc(1);
    expect_val("wrap_time", O_TIME, 32'h000000);
    expect_val("wrap_pulse", O_WRAP, 32'h1);
    expect_val("wrap_alarm", O_ALARM, 32'h1);
    check_now();
    cyc(1);
    expect_val("post_wrap", O_TIME, 32'h000001);
    expect_val("post_wrap_w", O_WRAP, 32'h0);
    check_now();

    // ---------------- down count to done ----------------
    clear = 1'b1; cyc(1); clear = 1'b0;
    expect_val("clr_time", O_TIME, 32'h0);
    expect_val("clr_run", O_RUN, 32'h0);
    expect_val("clr_alarm", O_ALARM, 32'h0);
    check_now();
    load = 1'b1; load_time = 24'h000100; cyc(1); load = 1'b0;
    mode = 1'b1; start = 1'b1; cyc(1); start = 1'b0;
    expect_val("dn_run", O_RUN, 32'h1);
    check_now();
    cyc(99);
    expect_val("dn_99", O_TIME, 32'h000001);
    expect_val("dn_99_done", O_DONE, 32'h0);
    check_now();
    cyc(1);
    expect_val("dn_zero", O_TIME, 32'h0);
    expect_val("dn_done", O_DONE, 32'h1);
    expect_val("dn_stopped", O_RUN, 32'h0);
    expect_val("dn_alarm", O_ALARM, 32'h1);
    check_now();
    start = 1'b1; cyc(1); start = 1'b0;
    expect_val("done_start_done", O_DONE, 32'h1);
    expect_val("done_start_run", O_RUN, 32'h0);
    check_now();
    load = 1'b1; load_time = 24'h000050; cyc(1); load = 1'b0;
    expect_val("done_load_done", O_DONE, 32'h0);
    expect_val("done_load_time", O_TIME, 32'h000050);
    check_now();
    load = 1'b1; load_time = 24'h000000; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    expect_val("dn_zero_start", O_RUN, 32'h0);
    check_now();
    mode = 1'b0;

    // ---------------- pause and lap in pause ----------------
    clear = 1'b1; cyc(1); clear = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(37);
    expect_val("run_37", O_TIME, 32'h000037);
    check_now();
    stop = 1'b1; cyc(1); stop = 1'b0;
    expect_val("stop_37", O_TIME, 32'h000037);
    check_now();
    cyc(50);
    expect_val("frozen_37", O_TIME, 32'h000037);
    check_now();
    lap = 1'b1; cyc(1); lap = 1'b0;
    expect_val("lap_pause_e", O_EMPTY, 32'h0);
    expect_val("lap_pause_t", O_LAPT, 32'h000037);
    check_now();
    start = 1'b1; cyc(1); start = 1'b0;
    expect_val("resume_37", O_TIME, 32'h000037);
    check_now();
    cyc(1);
    expect_val("resume_38", O_TIME, 32'h000038);
    check_now();
    lap_pop = 1'b1; cyc(1); lap_pop = 1'b0;
    expect_val("pop_empty", O_EMPTY, 32'h1);
    check_now();

    // ---------------- FIFO fill, overflow, ordered pops ----------------
    clear = 1'b1; cyc(1); clear = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    lap = 1'b1; cyc(5); lap = 1'b0;
    expect_val("fifo_full", O_FULL, 32'h1);
    expect_val("fifo_ovf", O_OVF, 32'h1);
    expect_val("fifo_head0", O_LAPT, 32'h000000);
    check_now();
    stop = 1'b1; cyc(1); stop = 1'b0;
    lap_pop = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cyc(1);
      expect_val("fifo_pop_head", O_LAPT, 32'(i));
      check_now();
    end
    cyc(1); lap_pop = 1'b0;
    expect_val("fifo_drained", O_EMPTY, 32'h1);
    expect_val("fifo_not_full", O_FULL, 32'h0);
    check_now();
    start = 1'b1; cyc(1); start = 1'b0;
    lap = 1'b1; cyc(4);
    expect_val("refill_full", O_FULL, 32'h1);
    expect_val("refill_head", O_LAPT, 32'h000005);
    check_now();
    lap_pop = 1'b1; cyc(1); lap = 1'b0; lap_pop = 1'b0;
    expect_val("pushpop_full", O_FULL, 32'h1);
    expect_val("pushpop_head", O_LAPT, 32'h000006);
    check_now();

    // ---------------- invalid loads, load in RUN, clear with laps ----------------
    stop = 1'b1; cyc(1); stop = 1'b0;
    expect_val("pause_10", O_TIME, 32'h000010);
    check_now();
    load = 1'b1; load_time = 24'h006A00; cyc(1);
    expect_val("bad_load_6A", O_TIME, 32'h000010);
    check_now();
    load_time = 24'h007000; cyc(1); load = 1'b0;
    expect_val("bad_load_70", O_TIME, 32'h000010);
    check_now();
    clear = 1'b1; cyc(1); clear = 1'b0;
    expect_val("clr_ovf", O_OVF, 32'h0);
    check_now();
    load = 1'b1; load_time = 24'h123453; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    load = 1'b1; load_time = 24'h000000; cyc(1); load = 1'b0;
    expect_val("load_in_run", O_TIME, 32'h123454);
    check_now();
    lap = 1'b1; cyc(2);
    expect_val("pre_clr_time", O_TIME, 32'h123456);
    expect_val("pre_clr_lap", O_LAPT, 32'h123454);
    check_now();
    clear = 1'b1; cyc(1); clear = 1'b0; lap = 1'b0;
    expect_val("clr_run_time", O_TIME, 32'h0);
    expect_val("clr_run_idle", O_RUN, 32'h0);
    expect_val("clr_run_empty", O_EMPTY, 32'h1);
    expect_val("clr_run_ovf", O_OVF, 32'h0);
    check_now();

    // ---------------- TICK_DIV=4 instance ----------------
    rst = 1'b1; cyc(1); rst = 1'b0;
    mode = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    cyc(40);
    expect_val("div4_40", O4_TIME, 32'h000010);
    check_now();
    cyc(3);
    expect_val("div4_43", O4_TIME, 32'h000010);
    check_now();
    stop = 1'b1; cyc(1); stop = 1'b0;
    expect_val("div4_stop_time", O4_TIME, 32'h000010);
    expect_val("div4_stop_run", O4_RUN, 32'h0);
    check_now();
    start = 1'b1; cyc(1); start = 1'b0;
    expect_val("div4_resume", O4_TIME, 32'h000010);
    expect_val("div4_resume_run", O4_RUN, 32'h1);
    check_now();
    cyc(1);
    expect_val("div4_pending", O4_TIME, 32'h000011);
    check_now();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
Parametrised successor to the lab stopwatch control. Runs an up-counting stopwatch or a down-counting timer in MM:SS.CC BCD, driven by a divided tick from the system clock. Adds preset load, start/stop run control, a terminal-count done flag, a configurable periodic alarm toggle, and a lap-capture FIFO. Sits between the debounced button/switch logic and the seven-segment display driver.

Parameters:
TICK_DIV, 1, clk_100hz cycles per centisecond tick (>=1)
ALARM_PERIOD_SEC, 30, alarm toggles every N whole seconds of elapsed/remaining time; legal values 1..60, divisors of 60 only
LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2)

Ports:
clk_100hz  in  1  sole clock
rst  in  1  synchronous, active-high reset
start  in  1  level-sampled each cycle; IDLE/PAUSE -> RUN
stop  in  1  RUN -> PAUSE
clear  in  1  return to IDLE, zero time, flush FIFO
mode  in  1  0 = count up, 1 = count down; latched on IDLE->RUN only
load  in  1  load load_time (IDLE/PAUSE/DONE only)
load_time  in  24  BCD nibbles {min_h,min_l,sec_h,sec_l,cs_h,cs_l}
lap  in  1  push current time into FIFO
lap_pop  in  1  pop FIFO head
time_bcd  out  24  current time, same nibble order as load_time
running  out  1  state == RUN
done  out  1  down-count reached 00:00.00
wrap  out  1  one-cycle pulse on up-count 59:59.99 -> 00:00.00
alarm  out  1  toggling alarm level
lap_time  out  24  FIFO head (don't-care when empty)
lap_empty  out  1  FIFO empty
lap_full  out  1  FIFO full
lap_ovf  out  1  sticky: lap dropped while full

Behaviour:
- Clock and reset: one clock, clk_100hz; reset rst is synchronous and active-high. On reset: state IDLE, time_bcd=0, divider=0, latched mode=0, running/done/wrap/alarm=0, FIFO empty (lap_empty=1, lap_full=0, lap_ovf=0).
- States: IDLE, RUN, PAUSE, DONE.
- Per-cycle command priority: rst > clear > load > stop > start. lap and lap_pop are independent of the command path.
- clear: from any state -> IDLE. Next cycle: time=0, divider=0, alarm=0, done=0, FIFO flushed, lap_ovf=0.
- load: honoured in IDLE, PAUSE, DONE; ignored in RUN.
  - Loaded digits must be in range min_h<=5, min_l<=9, sec_h<=5, sec_l<=9, cs_h<=9, cs_l<=9. Any out-of-range digit: whole load ignored.
  - Valid load from DONE -> IDLE with done=0; from IDLE/PAUSE the state is unchanged. Divider is zeroed.
- start:
  - IDLE -> RUN, latches mode, zeroes divider.
  - PAUSE -> RUN keeps mode and divider.
  - Ignored in DONE.
  - Ignored in IDLE when mode=1 and time=0.
- stop: RUN -> PAUSE. Time and divider do not advance on that edge.
- Divider: counts 0..TICK_DIV-1 only in RUN. A tick fires on the edge where the divider equals TICK_DIV-1, then the divider returns to 0. TICK_DIV=1 ticks every RUN cycle.
- Up count on tick: BCD ripple cs_l 9->0 carries to cs_h, cs_h 9->0 to sec_l, sec_l 9->0 to sec_h, sec_h 5->0 to min_l, min_l 9->0 to min_h, min_h 5->0. 59:59.99 -> 00:00.00 with wrap=1 for exactly that cycle; counting continues.
- Down count on tick: mirror borrow (sec_h/min_h 0->5, others 0->9). The tick producing 00:00.00 moves to DONE with done=1, running=0. done holds until clear or a valid load.
- Alarm: on any tick whose new time has cs=00 and (sec_h*10+sec_l) mod ALARM_PERIOD_SEC == 0, alarm inverts. Applies in both modes, including the terminal tick. Never toggles outside RUN.
- Lap FIFO:
  - Push: lap=1 in RUN or PAUSE pushes the pre-edge time_bcd. lap in IDLE/DONE is ignored.
  - Pop: lap_pop=1 with FIFO non-empty removes the head. Pop when empty is ignored.
  - Push and pop in the same cycle are both performed, including when full (count unchanged, order kept).
  - Push when full without pop: entry dropped, lap_ovf=1.
  - lap_time shows the head combinationally from storage, with zero cycles of added latency after the write edge.
  - clear beats lap on the same cycle (flush wins).
- rst mid-operation is identical to power-on reset.

Test Plan:
- TICK_DIV=1, mode=0, start, hold RUN 6000 cycles -> time passes 00:30.00 (alarm 0->1) and 01:00.00 (alarm 1->0). At 360000 cycles time=00:00.00 and wrap pulses exactly once.
- load 00:01.00, mode=1, start -> after 100 cycles time=00:00.00, done=1, running=0. A further start leaves the state DONE. load 00:00.50 -> IDLE, done=0.
- Up run, stop at 00:00.37 -> time frozen at 00:00.37 for 50 cycles. lap in PAUSE pushes 00:00.37. start resumes at 00:00.38 on the next tick.
- LAP_DEPTH=4: 5 laps at distinct times -> lap_full=1, lap_ovf=1, fifth lap lost. Four pops return the laps in order, then lap_empty=1. Push+pop while full keeps lap_full=1.
- load 00:6A.00 or 00:70.00 -> ignored, time unchanged. clear while running at 12:34.56 with 2 laps queued -> next cycle time=0, IDLE, lap_empty=1, lap_ovf=0.
- TICK_DIV=4: 40 RUN cycles -> time=00:00.10. stop on a divider=3 cycle: no increment; resume completes the pending tick 1 cycle later.
